rr_arbiter_4: RTL and testbench
===============================

Name: rr_arbiter_4

Overview:
- Sequencing arbiter for a shared 4-input resource (e.g. a 4x2 encoder path or a shared bus slot).
- Accepts up to four request lines and grants exactly one at a time, round-robin.
- Presents the winner both one-hot (gnt) and encoded (gnt_idx), with a bounded hold time per grant.
- Sits between requester blocks and the shared datapath; gnt_idx drives the datapath select.

Parameters:
- N_REQ, 4, number of requesters; fixed at 4 in this revision.
- IDX_W, 2, width of gnt_idx (log2 N_REQ).
- MAX_HOLD, 8, maximum consecutive cycles one grant may be held; legal range 1..255.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  arbiter enable; low forces release and blocks new grants.
- req  in  4  request lines; req[i] held high while requester i wants the resource.
- done  in  1  single-cycle pulse from the current holder: release now.
- gnt  out  4  one-hot grant; all zero when no grant.
- gnt_idx  out  2  encoded index of the granted requester; holds its last value when gnt_valid=0.
- gnt_valid  out  1  high while any grant is active.
- busy  out  1  high in GRANT state (equal to gnt_valid).

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, gnt=0000, gnt_idx=00, gnt_valid=0, busy=0, ptr=0, hold_cnt=0. rst has priority over all other inputs, including mid-grant.
- Registers: 2-state FSM {IDLE, GRANT}; 2-bit round-robin pointer ptr; hold_cnt of width 8.
- IDLE:
  - If en=1 and req!=0, pick the winner by searching req starting at index ptr, then ptr+1, wrapping mod 4.
  - Next edge: gnt=onehot(w), gnt_idx=w, gnt_valid=1, hold_cnt=0, state=GRANT.
  - Grant latency is 1 cycle from the request being sampled.
  - If en=0 or req=0, remain in IDLE with outputs unchanged.
- GRANT: release at the next edge if any of the following holds:
  - req[gnt_idx]=0;
  - done=1;
  - hold_cnt==MAX_HOLD-1;
  - en=0.
- On release: state=IDLE, gnt=0000, gnt_valid=0, ptr=(gnt_idx+1) mod 4, hold_cnt=0. gnt_idx is retained.
- Without release: hold_cnt increments and gnt is unchanged.
- At least one all-zero gnt cycle separates consecutive grants, including back-to-back grants to the same requester.
- A grant lasts at most MAX_HOLD cycles. MAX_HOLD=1 gives exactly one cycle per grant.
- Pointer wrap: after a grant to 3, ptr=0.
- Single requester: with only req[i] high continuously, that requester gets a MAX_HOLD-cycle grant, 1 idle cycle, then is granted again.
- Requests that change while in GRANT have no effect except req[gnt_idx] falling.
- Simultaneous release causes (e.g. done and timeout together) act as a single release.
- done while in IDLE is ignored.
- gnt is always one-hot or zero; gnt and gnt_idx are always consistent while gnt_valid=1.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- When defined: fixed priority, req[3] highest down to req[0] lowest, matching 4x2 priority-encoder ordering. ptr is not used for selection (it may still update). All hold, release and idle-cycle rules are unchanged.
- When undefined: round-robin as described above.

Decomposition:
- Package arb_pkg:
  - state enum {IDLE, GRANT};
  - constants N_REQ=4 and IDX_W=2;
  - hold-counter width constant HOLD_W=8.
- Sub-module rr_pick_4: combinational masked priority encoder.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: win_idx[1:0], win_valid.
  - The fixed-priority variant is selected inside it under ARB_FIXED_PRIO_EN.
- The FSM and counters stay in rr_arbiter_4.

Test Plan:
- Reset mid-grant: grant req=0010, assert rst for 1 cycle while in GRANT -> next cycle gnt=0000, gnt_valid=0, gnt_idx=00; then req=0001 -> gnt=0001 one cycle later (ptr=0).
- Round-robin rotation: req=1111 held, done pulsed on the 2nd grant cycle each time -> grant sequence 0001,0010,0100,1000,0001, each followed by one 0000 cycle.
- Hold timeout: MAX_HOLD=8, req=0100 held continuously, no done -> gnt=0100 for exactly 8 cycles, 0000 for 1, then 0100 again.
- Early release: grant to 1, drop req[1] after 3 cycles -> gnt=0000 at the next edge; next winner among req=1001 is idx 3 (ptr=2).
- Enable gating: en=0 with req=1111 -> gnt stays 0000 for 10 cycles; raise en -> gnt=onehot(ptr) after 1 cycle; drop en during GRANT -> release at the next edge.
- ARB_FIXED_PRIO_EN build: req=1111 with done after each grant -> gnt=1000 every grant; req=0011 -> gnt=0010.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-input arbiter.
// Used by rr_pick_4 and rr_arbiter_4.
package arb_pkg;

    localparam int N_REQ  = 4;
    localparam int IDX_W  = 2;
    localparam int HOLD_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] one;
        one = {{(N_REQ-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational winner selection: a masked priority encoder that searches req from ptr upward.
// Defining ARB_FIXED_PRIO_EN selects fixed priority instead (req[3] highest, ptr ignored).
module rr_pick_4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_valid
);

`ifdef ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Later iterations overwrite earlier ones, so the highest set index wins.
    always_comb begin
        win_idx   = '0;
        win_valid = (req != '0);
        for (int i = 0; i < N_REQ; i++) begin
            if (req[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end
`else
    logic [IDX_W-1:0] cand;
    logic             found;

    // cand wraps naturally mod 4 because it is only IDX_W bits wide.
    always_comb begin
        win_idx   = '0;
        win_valid = (req != '0);
        cand      = '0;
        found     = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ptr + IDX_W'(i);
            if (!found && req[cand]) begin
                win_idx = cand;
                found   = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for four requesters with a bounded hold time per grant.
// Build option ARB_FIXED_PRIO_EN switches the winner selection in rr_pick_4 to fixed priority.
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             busy,
    output logic             dbg_state
);

    // Handshake: a requester holds req[i] high until served; gnt appears one cycle after
    // the request is sampled in IDLE and stays until req[gnt_idx] falls, done pulses, en
    // drops or the hold limit is reached. Every grant is followed by at least one idle cycle.

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t       state_q, state_n;
    logic [IDX_W-1:0] ptr_q, ptr_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic [HOLD_W-1:0] hold_q, hold_n;

    logic [IDX_W-1:0] win_idx;
    logic             win_valid;
    logic             grant_start;
    logic             release_grant;

    rr_pick_4 u_pick (
        .req       (req),
        .ptr       (ptr_q),
        .win_idx   (win_idx),
        .win_valid (win_valid)
    );

    assign grant_start   = en && win_valid;
    assign release_grant = !req[idx_q] || done || (hold_q == HOLD_LAST) || !en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (grant_start)   state_n = GRANT;
            GRANT:   if (release_grant) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q  <= '0;
            idx_q  <= '0;
            hold_q <= '0;
        end else begin
            ptr_q  <= ptr_n;
            idx_q  <= idx_n;
            hold_q <= hold_n;
        end
    end

    // gnt_idx is deliberately left untouched on release so the datapath select stays stable.
    always_comb begin
        ptr_n  = ptr_q;
        idx_n  = idx_q;
        hold_n = hold_q;
        case (state_q)
            IDLE: begin
                if (grant_start) begin
                    idx_n  = win_idx;
                    hold_n = '0;
                end
            end
            GRANT: begin
                if (release_grant) begin
                    ptr_n  = idx_q + IDX_W'(1);
                    hold_n = '0;
                end else begin
                    hold_n = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                ptr_n  = '0;
                idx_n  = '0;
                hold_n = '0;
            end
        endcase
    end

    always_comb begin
        gnt_valid = (state_q == GRANT);
        busy      = gnt_valid;
        gnt       = gnt_valid ? idx_to_onehot(idx_q) : '0;
        gnt_idx   = idx_q;
        dbg_state = state_q;
    end

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_hold_bound:  assert property (@(posedge clk) disable iff (rst)
                                    (state_q == GRANT) |-> (hold_q < HOLD_W'(MAX_HOLD)));

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4; expectations follow ARB_FIXED_PRIO_EN when it is defined.
module tb_rr_arbiter_4;

    logic       clk = 1'b0;
    logic       rst, en, done;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid, busy, dbg_state;

    int tests = 0;
    int fails = 0;

`ifdef ARB_FIXED_PRIO_EN
    localparam logic [3:0] EN_FIRST = 4'b1000;
`else
    localparam logic [3:0] EN_FIRST = 4'b0001;
`endif

    always #5 clk = ~clk;

    rr_arbiter_4 #(.MAX_HOLD(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; req = 4'b0000; done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        tests++; if (gnt_idx !== 2'b00) begin fails++; $display("FAIL reset_idx: got %b want 00", gnt_idx); end
        tests++; if (gnt_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", gnt_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (dbg_state !== 1'b0) begin fails++; $display("FAIL reset_state: got %b want 0", dbg_state); end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        en = 1'b1; req = 4'b0010;
        tick();
        tests++; if (gnt !== 4'b0010) begin fails++; $display("FAIL midrst_grant: got %b want 0010", gnt); end
        tests++; if (gnt_idx !== 2'd1) begin fails++; $display("FAIL midrst_grant_idx: got %0d want 1", gnt_idx); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL midrst_gnt: got %b want 0000", gnt); end
        tests++; if (gnt_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b want 0", gnt_valid); end
        tests++; if (gnt_idx !== 2'b00) begin fails++; $display("FAIL midrst_idx: got %b want 00", gnt_idx); end
        req = 4'b0001;
        tick();
        tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL midrst_regrant: got %b want 0001", gnt); end
    endtask

`ifdef ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        do_reset();
        en = 1'b1; req = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++; if (gnt !== 4'b1000) begin fails++; $display("FAIL fixed_grant[%0d]: got %b want 1000", k, gnt); end
            done = 1'b1;
            tick();
            done = 1'b0;
            tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL fixed_gap[%0d]: got %b want 0000", k, gnt); end
        end
        req = 4'b0011;
        tick();
        tests++; if (gnt !== 4'b0010) begin fails++; $display("FAIL fixed_low: got %b want 0010", gnt); end
    endtask
`else
    task automatic test_round_robin();
        logic [3:0] exp_seq [5];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        en = 1'b1; req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            tests++; if (gnt !== exp_seq[k]) begin fails++; $display("FAIL rr_cyc1[%0d]: got %b want %b", k, gnt, exp_seq[k]); end
            tick();
            tests++; if (gnt !== exp_seq[k]) begin fails++; $display("FAIL rr_cyc2[%0d]: got %b want %b", k, gnt, exp_seq[k]); end
            done = 1'b1;
            tick();
            done = 1'b0;
            tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL rr_gap[%0d]: got %b want 0000", k, gnt); end
        end
    endtask
`endif

    task automatic test_hold_timeout();
        do_reset();
        en = 1'b1; req = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            tick();
            tests++; if (gnt !== 4'b0100) begin fails++; $display("FAIL hold_cyc[%0d]: got %b want 0100", k, gnt); end
        end
        tick();
        tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL hold_gap: got %b want 0000", gnt); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL hold_gap_busy: got %b want 0", busy); end
        tick();
        tests++; if (gnt !== 4'b0100) begin fails++; $display("FAIL hold_regrant: got %b want 0100", gnt); end
    endtask

    task automatic test_early_release();
        do_reset();
        en = 1'b1; req = 4'b0010;
        tick();
        tests++; if (gnt !== 4'b0010) begin fails++; $display("FAIL early_grant: got %b want 0010", gnt); end
        tick();
        tick();
        req = 4'b1001;
        tick();
        tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL early_release: got %b want 0000", gnt); end
        tests++; if (gnt_idx !== 2'd1) begin fails++; $display("FAIL early_idx_hold: got %0d want 1", gnt_idx); end
        tick();
        tests++; if (gnt !== 4'b1000) begin fails++; $display("FAIL early_next: got %b want 1000", gnt); end
        tests++; if (gnt_idx !== 2'd3) begin fails++; $display("FAIL early_next_idx: got %0d want 3", gnt_idx); end
        req = 4'b0000;
        tick();
        tests++; if (gnt_valid !== 1'b0) begin fails++; $display("FAIL early_drop_valid: got %b want 0", gnt_valid); end
        tests++; if (gnt_idx !== 2'd3) begin fails++; $display("FAIL early_idx_retain: got %0d want 3", gnt_idx); end
    endtask

    task automatic test_enable_gating();
        do_reset();
        en = 1'b0; req = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            done = (k % 3 == 0);
            tick();
            tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL en_block[%0d]: got %b want 0000", k, gnt); end
        end
        done = 1'b0;
        en = 1'b1;
        tick();
        tests++; if (gnt !== EN_FIRST) begin fails++; $display("FAIL en_grant: got %b want %b", gnt, EN_FIRST); end
        en = 1'b0;
        tick();
        tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL en_release: got %b want 0000", gnt); end
        tests++; if (gnt_valid !== 1'b0) begin fails++; $display("FAIL en_release_valid: got %b want 0", gnt_valid); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_grant();
`ifdef ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_round_robin();
`endif
        test_hold_timeout();
        test_early_release();
        test_enable_gating();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
